pipe_word_serializer: RTL

- Consumer stage directly downstream of the indication-output block.
- Accepts one 96-bit tagged indication message per pipe$enq transaction.
- Emits it as a sequence of 32-bit words on out$enq toward the host portal.
- Optionally prefixes each message with a framing header word; drops invalid (tag 0) messages and counts sent/dropped messages.

---
 rtl/pipe_word_serializer_if.sv | 12 +
 rtl/pipe_word_serializer.sv | 98 +++++++++
 2 files changed

// File: rtl/pipe_word_serializer_if.sv
// Single-direction enq handshake bundle: producer drives enq_ena/enq_v,
// consumer answers with enq_rdy. W sets the payload width.
interface pipe_word_serializer_if #(
  parameter int W = 32
);
  logic         enq_ena;
  logic [W-1:0] enq_v;
  logic         enq_rdy;

  modport master (output enq_ena, output enq_v, input enq_rdy);
  modport slave  (input enq_ena, input enq_v, output enq_rdy);
endinterface

// File: rtl/pipe_word_serializer.sv
// pipe_word_serializer: takes one 32*WORDS-bit tagged message per pipe
// transfer and emits it as 32-bit words on out, lowest word (tag) first.
// Messages with tag 0 are dropped and counted. Sent and dropped message
// counters wrap silently.
// Build option: define PIPE_WORD_SERIALIZER_HEADER_EN to prefix every
// message with a header word {WORDS[15:0], tag[15:0]}.
module pipe_word_serializer #(
  parameter int WORDS = 3,
  parameter int CNT_W = 16
) (
  input  logic                          CLK,
  input  logic                          nRST,  // async, active-high despite the name
  pipe_word_serializer_if.slave         pipe,
  pipe_word_serializer_if.master        out,
  output logic [CNT_W-1:0]              sent_count,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int IDX_W = $clog2(WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [15:0] WORDS_16 = 16'(WORDS);

`ifdef PIPE_WORD_SERIALIZER_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;  // hdr_pending never sets; header path folds away
`endif

  logic [WORDS-1:0][31:0] msg;
  logic                   busy;
  logic                   hdr_pending;
  logic [IDX_W-1:0]       idx;

  logic        accept;
  logic        fire;
  logic [31:0] in_tag;
  logic [31:0] hdr_word;

  assign in_tag   = pipe.enq_v[31:0];
  // Upstream is only offered space when idle, so accept and fire never overlap.
  assign accept   = pipe.enq_ena && !busy;
  assign fire     = busy && out.enq_rdy;
  assign hdr_word = {WORDS_16, msg[0][15:0]};

  // Ready is a function of registered state only: no path from out.enq_rdy.
  assign pipe.enq_rdy = !busy;
  assign out.enq_ena  = fire;

  // Word selection: header first when pending, then payload words by index.
  always_comb begin
    out.enq_v = '0;
    if (busy) begin
      out.enq_v = hdr_pending ? hdr_word : msg[idx];
    end
  end

  // Message register, word sequencing and message counters.
  // NOTE: msg is a plain register file of one message, so it is cleared on
  // reset along with the control flags; that keeps out.enq_v at 0 after reset.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      msg         <= '0;
      busy        <= 1'b0;
      idx         <= '0;
      hdr_pending <= 1'b0;
      sent_count  <= '0;
      drop_count  <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments everywhere here so every register
      // sees pre-edge values regardless of statement order.
      if (in_tag != 32'd0) begin
        msg         <= pipe.enq_v;
        busy        <= 1'b1;
        idx         <= '0;
        hdr_pending <= HDR_EN;
      end else begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end else if (fire) begin
      if (hdr_pending) begin
        hdr_pending <= 1'b0;
      end else if (idx == LAST_IDX) begin
        busy       <= 1'b0;
        idx        <= '0;
        sent_count <= sent_count + CNT_W'(1);
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  // Upstream must not offer a message while one is still being emitted.
  a_no_enq_while_busy: assert property (@(posedge CLK) disable iff (nRST)
    !(pipe.enq_ena && busy));
`endif

endmodule
